// File: rtl/bypass_network.sv
// bypass_network: writeback forwarding with DEPTH-stage history, load-use scoreboard and stall detection.
// Optional stall statistics counter enabled by defining BYPASS_STATS_EN.
module bypass_network #(
  parameter int NUM_WR = 3,
  parameter int NUM_RD = 8,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wb_valid,
  input  logic [NUM_WR*5-1:0]      wb_rd,
  input  logic [NUM_WR*XLEN-1:0]   wb_data,
  input  logic                     ld_issue_valid,
  input  logic [4:0]               ld_issue_rd,
  input  logic                     ld_done_valid,
  input  logic [4:0]               ld_done_rd,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        ex_rs_valid,
  input  logic [NUM_RD*5-1:0]      ex_rs,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD*XLEN-1:0]   fwd_data,
  output logic                     stall,
  output logic [31:0]              stall_cycles
);
  logic [NUM_WR-1:0]      sv    [0:DEPTH];
  logic [NUM_WR*5-1:0]    srd   [0:DEPTH];
  logic [NUM_WR*XLEN-1:0] sdata [0:DEPTH];
  logic [NUM_WR-1:0]      hv_q    [1:DEPTH];
  logic [NUM_WR-1:0]      hv_d    [1:DEPTH];
  logic [NUM_WR*5-1:0]    hrd_q   [1:DEPTH];
  logic [NUM_WR*5-1:0]    hrd_d   [1:DEPTH];
  logic [NUM_WR*XLEN-1:0] hdata_q [1:DEPTH];
  logic [NUM_WR*XLEN-1:0] hdata_d [1:DEPTH];
  logic [31:0]            pend_q, pend_d;

  always_comb begin
    sv[0]    = wb_valid;
    srd[0]   = wb_rd;
    sdata[0] = wb_data;
    for (int k = 1; k <= DEPTH; k++) begin
      sv[k]    = hv_q[k];
      srd[k]   = hrd_q[k];
      sdata[k] = hdata_q[k];
    end
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      hv_d[k]    = flush ? '0 : sv[k-1];
      hrd_d[k]   = srd[k-1];
      hdata_d[k] = sdata[k-1];
    end
  end

  // set is applied after clear so a same-cycle issue wins; flush overrides both
  always_comb begin
    pend_d = pend_q;
    if (ld_done_valid) pend_d[ld_done_rd] = 1'b0;
    if (ld_issue_valid && ld_issue_rd != 5'd0) pend_d[ld_issue_rd] = 1'b1;
    if (flush) pend_d = '0;
  end

  // scan oldest to youngest, highest port to lowest, so the last match written is the winner
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    stall    = 1'b0;
    for (int j = 0; j < NUM_RD; j++) begin
      for (int k = DEPTH; k >= 0; k--) begin
        for (int i = NUM_WR - 1; i >= 0; i--) begin
          if (ex_rs_valid[j] && ex_rs[j*5+:5] != 5'd0 && sv[k][i] && srd[k][i*5+:5] == ex_rs[j*5+:5]) begin
            fwd_hit[j]             = 1'b1;
            fwd_data[j*XLEN+:XLEN] = sdata[k][i*XLEN+:XLEN];
          end
        end
      end
      if (ex_rs_valid[j] && pend_q[ex_rs[j*5+:5]] && !(ld_done_valid && ld_done_rd == ex_rs[j*5+:5]))
        stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) hv_q[k] <= '0;
      pend_q <= '0;
    end else begin
      hv_q   <= hv_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    hrd_q   <= hrd_d;
    hdata_q <= hdata_d;
  end

`ifdef BYPASS_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = (stall && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = '0;
`endif
endmodule
